// File: rtl/dmem_arbiter.sv
// Two-port (A: pipeline MEM stage, B: loader/debug) arbiter in front of a single-ported data memory.
// Each access is IDLE (grant) -> ACCESS (memory strobe) -> RESP (done pulse).
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 256,
  parameter bit          FAIR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  state_t      r_state;
  state_t      w_next;
  logic        r_lastB;
  logic        r_id;
  logic        r_we;
  logic        r_illegal;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_anyReq;
  logic        w_selA;
  logic        w_selB;
  logic        w_reqWe;
  logic [31:0] w_reqAddr;
  logic [31:0] w_reqWdata;
  logic        w_reqIllegal;

  // On a tie A wins unless fairness is on and A was the last one served.
  assign w_anyReq     = a_req | b_req;
  assign w_selA       = a_req & (~b_req | ~FAIR | r_lastB);
  assign w_selB       = b_req & ~w_selA;
  assign w_reqWe      = w_selB ? b_we    : a_we;
  assign w_reqAddr    = w_selB ? b_addr  : a_addr;
  assign w_reqWdata   = w_selB ? b_wdata : a_wdata;
  assign w_reqIllegal = (w_reqAddr[1:0] != 2'b00) || (w_reqAddr > MAX_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lastB   <= 1'b1;
      r_id      <= 1'b0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_anyReq) begin
        r_id      <= w_selB;
        r_we      <= w_reqWe;
        r_addr    <= w_reqAddr;
        r_wdata   <= w_reqWdata;
        r_illegal <= w_reqIllegal;
        r_lastB   <= w_selB;
      end
      if (r_state == ACCESS) begin
        r_rdata <= (!r_illegal && !r_we) ? mem_rdata : 32'h0;
      end
    end
  end

  // Grants are held off while reset is asserted so every output reads 0 during reset.
  always_comb begin
    w_next    = r_state;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    a_err     = 1'b0;
    b_err     = 1'b0;
    a_rdata   = 32'h0;
    b_rdata   = 32'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_anyReq && !rst) begin
          a_gnt  = w_selA;
          b_gnt  = w_selB;
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_write = !r_illegal && r_we;
        mem_read  = !r_illegal && !r_we;
        w_next    = RESP;
      end
      RESP: begin
        if (r_id) begin
          b_done  = 1'b1;
          b_err   = r_illegal;
          b_rdata = r_rdata;
        end else begin
          a_done  = 1'b1;
          a_err   = r_illegal;
          a_rdata = r_rdata;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: byte-array memory model plus a transaction-level reference memory.
// A second instance with FAIR=0 checks fixed-priority arbitration.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;

  logic        f_a_req, f_b_req;
  logic        f_a_gnt, f_a_done, f_a_err, f_b_gnt, f_b_done, f_b_err;
  logic [31:0] f_a_rdata, f_b_rdata, f_mem_addr, f_mem_wdata;
  logic        f_mem_write, f_mem_read, f_busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] refMem [256];

  typedef struct {
    int          gntCyc;
    int          strobeCyc;
    int          doneCyc;
    int          writeCnt;
    int          readCnt;
    logic [31:0] strobeAddr;
    logic [31:0] strobeWdata;
    logic [31:0] rdata;
    logic        err;
    bit          otherBad;
    bit          protoBad;
  } obs_t;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(256), .FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.MEM_BYTES(256), .FAIR(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(f_a_req), .a_we(1'b0), .a_addr(32'h0), .a_wdata(32'h0),
    .a_gnt(f_a_gnt), .a_done(f_a_done), .a_rdata(f_a_rdata), .a_err(f_a_err),
    .b_req(f_b_req), .b_we(1'b0), .b_addr(32'h4), .b_wdata(32'h0),
    .b_gnt(f_b_gnt), .b_done(f_b_done), .b_rdata(f_b_rdata), .b_err(f_b_err),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_write(f_mem_write),
    .mem_read(f_mem_read), .mem_rdata(32'h0), .busy(f_busy)
  );

  // Attached memory: combinational big-endian read, write commits on the rising edge.
  always_comb mem_rdata = {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                           mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:0]]        <= mem_wdata[31:24];
      mem[mem_addr[7:0] + 8'd1] <= mem_wdata[23:16];
      mem[mem_addr[7:0] + 8'd2] <= mem_wdata[15:8];
      mem[mem_addr[7:0] + 8'd3] <= mem_wdata[7:0];
    end
  end

  function automatic bit isLegal(input logic [31:0] addr);
    return (addr % 4 == 0) && ({1'b0, addr} + 33'd4 <= 33'd256);
  endfunction

  function automatic logic [31:0] refWord(input logic [31:0] addr);
    return {refMem[addr[7:0]], refMem[addr[7:0] + 8'd1], refMem[addr[7:0] + 8'd2], refMem[addr[7:0] + 8'd3]};
  endfunction

  task automatic refWrite(input logic [31:0] addr, input logic [31:0] data);
    refMem[addr[7:0]]        = data[31:24];
    refMem[addr[7:0] + 8'd1] = data[23:16];
    refMem[addr[7:0] + 8'd2] = data[15:8];
    refMem[addr[7:0] + 8'd3] = data[7:0];
  endtask

  // Drives one request on one port and records what the DUT did, cycle by cycle after the request.
  task automatic doTxn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output obs_t o);
    o.gntCyc = -1; o.strobeCyc = -1; o.doneCyc = -1; o.writeCnt = 0; o.readCnt = 0;
    o.strobeAddr = 32'h0; o.strobeWdata = 32'h0; o.rdata = 32'h0; o.err = 1'b0;
    o.otherBad = 0; o.protoBad = 0;
    @(posedge clk); #1;
    if (port == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if ((a_gnt && b_gnt) || ((a_gnt || b_gnt) && busy)) o.protoBad = 1;
      if (port ? a_gnt : b_gnt) o.protoBad = 1;
      if ((port ? b_gnt : a_gnt) && o.gntCyc < 0) o.gntCyc = k;
      if (mem_write) begin
        o.writeCnt++; o.strobeCyc = k; o.strobeAddr = mem_addr; o.strobeWdata = mem_wdata;
      end
      if (mem_read) begin
        o.readCnt++; o.strobeCyc = k; o.strobeAddr = mem_addr;
      end
      if (port ? (a_done || a_err || a_rdata != 0) : (b_done || b_err || b_rdata != 0)) o.otherBad = 1;
      if (port ? b_done : a_done) begin
        o.doneCyc = k;
        o.rdata = port ? b_rdata : a_rdata;
        o.err = port ? b_err : a_err;
        break;
      end
      if (o.gntCyc == k) begin
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req = 1'b1; b_req = 1'b1; a_addr = 32'h8; b_addr = 32'hC;
    @(negedge clk);
    checks++;
    if ({a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata,
         mem_addr, mem_wdata, mem_write, mem_read, busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got gnt=%b/%b done=%b/%b busy=%b mem_rd=%b mem_wr=%b, expected all 0",
               a_gnt, b_gnt, a_done, b_done, busy, mem_read, mem_write);
    end
    a_req = 1'b0; b_req = 1'b0; f_a_req = 1'b0; f_b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_spec_read();
    obs_t o;
    doTxn(1'b0, 1'b0, 32'h4, 32'h0, o);
    checks++;
    if (o.gntCyc !== 0 || o.strobeCyc !== 1 || o.doneCyc !== 2) begin
      failures++;
      $display("[TB] FAIL spec_read_latency: got gnt/strobe/done=%0d/%0d/%0d, expected 0/1/2",
               o.gntCyc, o.strobeCyc, o.doneCyc);
    end
    checks++;
    if (o.readCnt !== 1 || o.writeCnt !== 0 || o.strobeAddr !== 32'h4) begin
      failures++;
      $display("[TB] FAIL spec_read_strobe: got reads=%0d writes=%0d addr=%h, expected 1/0/00000004",
               o.readCnt, o.writeCnt, o.strobeAddr);
    end
    checks++;
    if (o.rdata !== 32'h8CA40006 || o.err !== 1'b0 || o.otherBad) begin
      failures++;
      $display("[TB] FAIL spec_read_data: got rdata=%h err=%b otherBad=%0d, expected 8ca40006/0/0",
               o.rdata, o.err, o.otherBad);
    end
  endtask

  task automatic test_write_read_b();
    obs_t o;
    doTxn(1'b1, 1'b1, 32'h10, 32'h11223344, o);
    refWrite(32'h10, 32'h11223344);
    checks++;
    if (o.writeCnt !== 1 || o.readCnt !== 0 || o.strobeAddr !== 32'h10 || o.strobeWdata !== 32'h11223344) begin
      failures++;
      $display("[TB] FAIL b_write_strobe: got writes=%0d reads=%0d addr=%h wdata=%h, expected 1/0/00000010/11223344",
               o.writeCnt, o.readCnt, o.strobeAddr, o.strobeWdata);
    end
    checks++;
    if (o.doneCyc !== 2 || o.err !== 1'b0 || o.rdata !== 32'h0 || o.otherBad) begin
      failures++;
      $display("[TB] FAIL b_write_resp: got done@%0d err=%b rdata=%h otherBad=%0d, expected 2/0/0/0",
               o.doneCyc, o.err, o.rdata, o.otherBad);
    end
    doTxn(1'b1, 1'b0, 32'h10, 32'h0, o);
    checks++;
    if (o.rdata !== 32'h11223344 || o.err !== 1'b0 || o.doneCyc !== 2) begin
      failures++;
      $display("[TB] FAIL b_readback: got rdata=%h err=%b done@%0d, expected 11223344/0/2",
               o.rdata, o.err, o.doneCyc);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [31:0] addrs [4];
    bit          wes [4];
    addrs = '{32'h6, 32'h100, 32'h21, 32'hFFFFFFFC};
    wes   = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      doTxn(1'b0, wes[i], addrs[i], 32'hDEADBEEF, o);
      checks++;
      if (o.readCnt !== 0 || o.writeCnt !== 0 || o.doneCyc !== 2 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
        failures++;
        $display("[TB] FAIL illegal_%h: got reads=%0d writes=%0d done@%0d err=%b rdata=%h, expected 0/0/2/1/0",
                 addrs[i], o.readCnt, o.writeCnt, o.doneCyc, o.err, o.rdata);
      end
    end
  endtask

  task automatic test_fairness();
    int  grants = 0;
    int  fA = 0;
    int  fB = 0;
    bit  expectB = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h4;
    f_a_req = 1'b1; f_b_req = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (a_gnt || b_gnt) begin
        checks++;
        if (a_gnt === b_gnt || b_gnt !== expectB || busy) begin
          failures++;
          $display("[TB] FAIL fair_grant_%0d: got a_gnt=%b b_gnt=%b busy=%b, expected winner %s",
                   grants, a_gnt, b_gnt, busy, expectB ? "B" : "A");
        end
        grants++;
        expectB = ~expectB;
      end
      if (f_a_gnt) fA++;
      if (f_b_gnt || f_b_done) fB++;
    end
    checks++;
    if (grants !== 8) begin
      failures++;
      $display("[TB] FAIL fair_grant_count: got %0d, expected 8", grants);
    end
    checks++;
    if (fA !== 8 || fB !== 0) begin
      failures++;
      $display("[TB] FAIL fixed_priority: got A grants=%0d B activity=%0d, expected 8/0", fA, fB);
    end
    a_req = 1'b0; b_req = 1'b0; f_a_req = 1'b0; f_b_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    obs_t        o;
    logic [31:0] oldWord;
    logic [31:0] newWord;
    bit          doneSeen = 0;
    oldWord = refWord(32'h20);
    newWord = ~oldWord;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = newWord;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_gnt: got a_gnt=%b, expected 1", a_gnt);
    end
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h20) begin
      failures++;
      $display("[TB] FAIL abort_access: got mem_write=%b addr=%h, expected 1/00000020", mem_write, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_strobe: got mem_write=%b busy=%b, expected 0/0", mem_write, busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_done || b_done || busy) doneSeen = 1;
    end
    checks++;
    if (doneSeen) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got done/busy activity after abort, expected none");
    end
    doTxn(1'b0, 1'b0, 32'h20, 32'h0, o);
    checks++;
    if (o.rdata !== oldWord || o.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_mem_unchanged: got %h err=%b, expected %h/0", o.rdata, o.err, oldWord);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    bit          port;
    bit          we;
    bit          legal;
    int          r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    for (int n = 0; n < 40; n++) begin
      port  = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      r     = int'($urandom_range(0, 9));
      if (r < 7)       addr = 32'($urandom_range(0, 63) * 4);
      else if (r == 7) addr = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
      else if (r == 8) addr = 32'h100 + 32'($urandom_range(0, 255) * 4);
      else             addr = 32'hFFFFFFFC - 32'($urandom_range(0, 3) * 4);
      legal    = isLegal(addr);
      expRdata = (legal && !we) ? refWord(addr) : 32'h0;
      doTxn(port, we, addr, wdata, o);
      if (legal && we) refWrite(addr, wdata);
      checks++;
      if (o.gntCyc !== 0 || o.doneCyc !== 2 || o.protoBad || o.otherBad) begin
        failures++;
        $display("[TB] FAIL rand%0d_protocol: got gnt@%0d done@%0d protoBad=%0d otherBad=%0d, expected 0/2/0/0",
                 n, o.gntCyc, o.doneCyc, o.protoBad, o.otherBad);
      end
      checks++;
      if (o.writeCnt !== int'(legal && we) || o.readCnt !== int'(legal && !we) ||
          (legal && (o.strobeCyc !== 1 || o.strobeAddr !== addr)) ||
          (legal && we && o.strobeWdata !== wdata)) begin
        failures++;
        $display("[TB] FAIL rand%0d_strobe: got writes=%0d reads=%0d @%0d addr=%h wdata=%h, expected legal=%0d we=%0d addr=%h wdata=%h",
                 n, o.writeCnt, o.readCnt, o.strobeCyc, o.strobeAddr, o.strobeWdata, legal, we, addr, wdata);
      end
      checks++;
      if (o.rdata !== expRdata || o.err !== !legal) begin
        failures++;
        $display("[TB] FAIL rand%0d_resp: port=%0d addr=%h got rdata=%h err=%b, expected %h/%b",
                 n, port, addr, o.rdata, o.err, expRdata, !legal);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    f_a_req = 1'b0; f_b_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'($urandom);
      refMem[i] = mem[i];
    end
    mem[4] = 8'h8C; mem[5] = 8'hA4; mem[6] = 8'h00; mem[7] = 8'h06;
    refWrite(32'h4, 32'h8CA40006);
    test_reset();
    test_spec_read();
    test_write_read_b();
    test_illegal();
    test_fairness();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 256: byte size of the attached data memory; legal byte addresses are 0 to MEM_BYTES-4 for word access.
REQ-002 Parameter FAIR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with port A always winning.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a_req  input  1  port A (pipeline MEM stage) access request; held with a_we/a_addr/a_wdata stable until a_gnt.
REQ-006 a_we  input  1  port A direction: 1 = word write, 0 = word read.
REQ-007 a_addr  input  32  port A byte address.
REQ-008 a_wdata  input  32  port A write word, big-endian byte order in memory.
REQ-009 a_gnt  output  1  port A request accepted, one-cycle pulse.
REQ-010 a_done  output  1  port A access complete, one-cycle pulse.
REQ-011 a_rdata  output  32  port A read word, valid while a_done=1.
REQ-012 a_err  output  1  port A access rejected, valid while a_done=1.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata, b_err: identical set for port B (loader/debug), same widths and meanings.
REQ-014 mem_addr  output  32  byte address to the data memory.
REQ-015 mem_wdata  output  32  write word to the data memory.
REQ-016 mem_write  output  1  memory write strobe; memory commits on the rising clk edge while high.
REQ-017 mem_read  output  1  memory read enable.
REQ-018 mem_rdata  input  32  combinational read word from the data memory.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-021 IDLE: if any req is high, the winner's gnt SHALL be asserted combinationally in that cycle; at the edge, the FSM SHALL latch the winner's id, we, addr and wdata, then move to ACCESS. With no req, the FSM SHALL stay in IDLE.
REQ-022 Arbitration: with one req high, that port SHALL win. With both high and FAIR=1, the port not served last SHALL win. With both high and FAIR=0, A SHALL win.
REQ-023 The last-served pointer SHALL update on every grant.
REQ-024 A latched request SHALL be flagged illegal when addr[1:0]!=0 or addr>MEM_BYTES-4; address arithmetic SHALL be 32-bit unsigned with no wrap.
REQ-025 ACCESS lasts exactly 1 cycle: mem_addr and mem_wdata SHALL carry the latched values.
REQ-026 In ACCESS, legal write: mem_write=1, mem_read=0.
REQ-027 In ACCESS, legal read: mem_read=1, mem_write=0, and mem_rdata SHALL be registered at the exiting edge.
REQ-028 In ACCESS, illegal request: both strobes SHALL stay 0.
REQ-029 RESP lasts exactly 1 cycle: the served port's done=1. rdata SHALL be the registered word for a legal read and 0 otherwise. err SHALL be 1 only for an illegal request. The FSM then SHALL return to IDLE.
REQ-030 Latency: gnt in cycle N, memory strobe in N+1, done in N+2; the next gnt is no earlier than N+3.
REQ-031 Outside ACCESS: mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
REQ-032 gnt SHALL never be asserted outside IDLE, and at most one gnt SHALL be high per cycle.
REQ-033 A req dropped before gnt SHALL be ignored, with no access. A req held after done SHALL be treated as a new request.
REQ-034 The non-served port's done, err and rdata SHALL be 0 at all times.

Reset
REQ-035 On rst: FSM=IDLE, last-served pointer=B (so A wins the first tie), latched request and rdata register cleared, all outputs 0.
REQ-036 rst asserted mid-ACCESS or mid-RESP SHALL abort immediately: the strobe drops, no done is produced and the pending access is lost; the requester must re-request.

Verification
REQ-037 A read addr 0x4, memory 0x8CA40006 at bytes 4..7 -> a_gnt in cycle N, mem_read=1 with mem_addr=0x4 in N+1, a_done=1 with a_rdata=0x8CA40006 and a_err=0 in N+2.
REQ-038 B write 0x11223344 to 0x10, then B read 0x10 -> mem_write exactly one cycle; the read returns 0x11223344.
REQ-039 A and B request together continuously, FAIR=1 -> grants alternate A,B,A,B starting with A. With FAIR=0 -> A only, and B is starved while A holds req.
REQ-040 A read 0x6 (misaligned) and A read 0x100 (out of range) -> no mem strobe, a_done=1, a_err=1, a_rdata=0.
REQ-041 rst pulsed in the ACCESS cycle of a write to 0x20 -> no done pulse, busy=0 after reset, and memory bytes 0x20..0x23 unchanged if rst precedes the edge.
